// File: rtl/uart_pkg.sv
// Shared UART definitions: parity encodings, controller states and the default
// bit period, used by the transmitter and the receiver.
package uart_pkg;

  localparam int UART_CLOCK  = 434;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_state_t;

  function automatic logic [7:0] data_mask(input int bits);
    return 8'((1 << bits) - 1);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered occupancy count; the read port shows the
// head entry combinationally so a pop and its data land on the same edge.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clock_50M,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   rd_en,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push;
  logic             pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign push    = wr_en && !full;
  assign pop     = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clock_50M) begin
    if (push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock_50M) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + (PTR_W + 1)'(1);
        2'b01:   count <= count - (PTR_W + 1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a transmit FIFO; frames go out LSB-first and
// back-to-back while data is queued, with every line output registered.
//
// state     | meaning
// ST_IDLE   | line high, waiting for the FIFO to hold a byte
// ST_START  | start bit (low) for one bit period
// ST_DATA   | data bits, LSB first
// ST_PARITY | parity bit, only when parity is enabled
// ST_STOP   | stop bit(s) high; tx_done on the final cycle
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLOCK,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = PARITY_NONE,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                          clock_50M,
  input  logic                          rst,
  input  logic [7:0]                    wr_data,
  input  logic                          wr_valid,
  output logic                          wr_ready,
  output logic                          tx,
  output logic                          busy,
  output logic                          tx_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int DIV_W = $clog2(CLKS_PER_BIT);

  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       DATA_LAST  = 3'(DATA_BITS - 1);
  localparam logic [2:0]       STOP_LAST  = 3'(STOP_BITS - 1);
  localparam logic [7:0]       DATA_MASK  = data_mask(DATA_BITS);
  localparam logic             HAS_PARITY = (PARITY != PARITY_NONE);
  localparam logic             PAR_INV    = (PARITY == PARITY_ODD);

  uart_state_t      state;
  uart_state_t      next_state;
  logic [DIV_W-1:0] div_cnt;
  logic [DIV_W-1:0] div_d;
  logic [2:0]       bit_cnt;
  logic [2:0]       bit_d;
  logic [7:0]       shift_reg;
  logic [7:0]       shift_d;
  logic             parity_bit;
  logic             parity_d;
  logic             tx_d;
  logic             busy_d;
  logic             done_d;
  logic             pop;
  logic             div_end;
  logic             bit_last;
  logic             fifo_full;
  logic             fifo_empty;
  logic [7:0]       fifo_rd_data;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock_50M (clock_50M),
    .rst       (rst),
    .wr_en     (wr_valid),
    .wr_data   (wr_data),
    .rd_en     (pop),
    .rd_data   (fifo_rd_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign wr_ready = !fifo_full;
  assign div_end  = (div_cnt == DIV_LAST);
  assign bit_last = (state == ST_STOP) ? (bit_cnt == STOP_LAST) : (bit_cnt == DATA_LAST);

  always_ff @(posedge clock_50M) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) next_state = ST_START;
      end
      ST_START: begin
        if (div_end) next_state = ST_DATA;
      end
      ST_DATA: begin
        if (div_end && bit_last) next_state = HAS_PARITY ? ST_PARITY : ST_STOP;
      end
      ST_PARITY: begin
        if (div_end) next_state = ST_STOP;
      end
      ST_STOP: begin
        if (div_end && bit_last) next_state = fifo_empty ? ST_IDLE : ST_START;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Outputs are computed from the next-cycle view so that tx, busy and
  // tx_done can be registered and still line up with the state register.
  always_comb begin
    pop = !fifo_empty &&
          ((state == ST_IDLE) || (state == ST_STOP && div_end && bit_last));

    div_d = (state == ST_IDLE || div_end) ? '0 : div_cnt + DIV_W'(1);

    if (next_state != state) begin
      bit_d = '0;
    end else if (div_end) begin
      bit_d = bit_cnt + 3'd1;
    end else begin
      bit_d = bit_cnt;
    end

    shift_d  = shift_reg;
    parity_d = parity_bit;
    if (pop) begin
      shift_d  = fifo_rd_data & DATA_MASK;
      parity_d = (^(fifo_rd_data & DATA_MASK)) ^ PAR_INV;
    end else if (state == ST_DATA && div_end) begin
      shift_d = shift_reg >> 1;
    end

    case (next_state)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = shift_d[0];
      ST_PARITY: tx_d = parity_bit;
      default:   tx_d = 1'b1;
    endcase

    busy_d = (next_state != ST_IDLE);
    done_d = (next_state == ST_STOP) && (div_d == DIV_LAST) && (bit_d == STOP_LAST);
  end

  always_ff @(posedge clock_50M) begin
    if (rst) begin
      div_cnt    <= '0;
      bit_cnt    <= '0;
      shift_reg  <= '0;
      parity_bit <= 1'b0;
      tx         <= 1'b1;
      busy       <= 1'b0;
      tx_done    <= 1'b0;
    end else begin
      div_cnt    <= div_d;
      bit_cnt    <= bit_d;
      shift_reg  <= shift_d;
      parity_bit <= parity_d;
      tx         <= tx_d;
      busy       <= busy_d;
      tx_done    <= done_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: three frame formats at 4 clocks per bit,
// line traces recorded shortly after each rising edge.
module tb_uart_tx_fifo;

  localparam int REC_N = 800;

  logic       clock_50M = 1'b0;
  logic       rst       = 1'b1;

  logic [7:0] wr_data_a = '0, wr_data_b = '0, wr_data_c = '0;
  logic       wr_valid_a = 1'b0, wr_valid_b = 1'b0, wr_valid_c = 1'b0;
  logic       wr_ready_a, wr_ready_b, wr_ready_c;
  logic       tx_a, tx_b, tx_c;
  logic       busy_a, busy_b, busy_c;
  logic       tx_done_a, tx_done_b, tx_done_c;
  logic [4:0] cnt_a, cnt_b, cnt_c;

  int n_vec = 0;
  int n_bad = 0;

  logic [1:0] rec_sel = 2'd0;
  logic       rec_on  = 1'b0;
  int         rec_idx = 0;
  logic       rec_tx   [REC_N];
  logic       rec_done [REC_N];
  logic       rec_busy [REC_N];
  logic       tx_m, done_m, busy_m;

  always #5 clock_50M = ~clock_50M;

  uart_tx_fifo #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(16)) dut_8n1 (
    .clock_50M (clock_50M), .rst (rst), .wr_data (wr_data_a), .wr_valid (wr_valid_a),
    .wr_ready (wr_ready_a), .tx (tx_a), .busy (busy_a), .tx_done (tx_done_a), .fifo_count (cnt_a));

  uart_tx_fifo #(.CLKS_PER_BIT(4), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(16)) dut_7e2 (
    .clock_50M (clock_50M), .rst (rst), .wr_data (wr_data_b), .wr_valid (wr_valid_b),
    .wr_ready (wr_ready_b), .tx (tx_b), .busy (busy_b), .tx_done (tx_done_b), .fifo_count (cnt_b));

  uart_tx_fifo #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(16)) dut_8o1 (
    .clock_50M (clock_50M), .rst (rst), .wr_data (wr_data_c), .wr_valid (wr_valid_c),
    .wr_ready (wr_ready_c), .tx (tx_c), .busy (busy_c), .tx_done (tx_done_c), .fifo_count (cnt_c));

  assign tx_m   = (rec_sel == 2'd0) ? tx_a      : (rec_sel == 2'd1) ? tx_b      : tx_c;
  assign done_m = (rec_sel == 2'd0) ? tx_done_a : (rec_sel == 2'd1) ? tx_done_b : tx_done_c;
  assign busy_m = (rec_sel == 2'd0) ? busy_a    : (rec_sel == 2'd1) ? busy_b    : busy_c;

  // r = 0 holds the state just after the edge that accepted the first write.
  always @(posedge clock_50M) begin
    #2;
    if (rec_on) begin
      if (rec_idx < REC_N) begin
        rec_tx[rec_idx]   = tx_m;
        rec_done[rec_idx] = done_m;
        rec_busy[rec_idx] = busy_m;
      end
      rec_idx = rec_idx + 1;
    end else begin
      rec_idx = 0;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_wr(input int sel, input logic v, input logic [7:0] d);
    wr_valid_a = (sel == 0) && v;
    wr_valid_b = (sel == 1) && v;
    wr_valid_c = (sel == 2) && v;
    wr_data_a  = d;
    wr_data_b  = d;
    wr_data_c  = d;
  endtask

  function automatic logic [4:0] cnt_of(input int sel);
    return (sel == 0) ? cnt_a : (sel == 1) ? cnt_b : cnt_c;
  endfunction

  function automatic logic tx_of(input int sel);
    return (sel == 0) ? tx_a : (sel == 1) ? tx_b : tx_c;
  endfunction

  // Reads a byte back from the recorded line, mid-bit, first data bit at r0.
  function automatic logic [7:0] line_byte(input int r0, input int nb);
    logic [7:0] v;
    v = '0;
    for (int b = 0; b < nb; b++) v[b] = rec_tx[r0 + 4 * b + 1];
    return v;
  endfunction

  function automatic int done_count(input int r_lo, input int r_hi);
    int n;
    n = 0;
    for (int r = r_lo; r <= r_hi; r++) if (rec_done[r] === 1'b1) n++;
    return n;
  endfunction

  // Sends one byte and compares the line bit by bit; exp_line[i] is line bit i.
  task automatic run_frame(input int sel, input logic [7:0] data, input int nb,
                           input logic [10:0] exp_line, input string tag);
    int bad;
    int flen;
    flen = nb * 4;
    repeat (2) @(negedge clock_50M);
    rec_sel = 2'(sel);
    set_wr(sel, 1'b1, data);
    rec_on = 1'b1;
    @(negedge clock_50M);
    set_wr(sel, 1'b0, 8'h00);
    check({tag, " count after accept"}, 32'(cnt_of(sel)), 1);
    check({tag, " tx idle on accept"}, 32'(tx_of(sel)), 1);
    repeat (flen + 2) @(negedge clock_50M);
    rec_on = 1'b0;
    bad = 0;
    for (int r = 1; r <= flen; r++) if (rec_tx[r] !== exp_line[(r - 1) / 4]) bad++;
    check({tag, " line bits"}, 32'(bad), 0);
    check({tag, " start 1 cycle late"}, 32'(rec_tx[1]), 0);
    check({tag, " busy at start"}, 32'(rec_busy[1]), 1);
    check({tag, " tx_done pulses"}, 32'(done_count(0, flen + 2)), 1);
    check({tag, " tx_done on last"}, 32'(rec_done[flen]), 1);
    check({tag, " busy last cycle"}, 32'(rec_busy[flen]), 1);
    check({tag, " busy after frame"}, 32'(rec_busy[flen + 1]), 0);
    check({tag, " tx after frame"}, 32'(rec_tx[flen + 1]), 1);
  endtask

  initial begin
    int lows;
    int acc;
    int drop_at;
    int dones;

    // Reset and idle line
    repeat (3) @(posedge clock_50M);
    @(negedge clock_50M);
    check("reset tx", 32'(tx_a), 1);
    check("reset busy", 32'(busy_a), 0);
    check("reset wr_ready", 32'(wr_ready_a), 1);
    check("reset count", 32'(cnt_a), 0);
    check("reset tx_done", 32'(tx_done_a), 0);
    rst = 1'b0;
    lows = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock_50M);
      if (tx_a !== 1'b1 || tx_b !== 1'b1 || tx_c !== 1'b1) lows++;
    end
    check("idle tx stays high", 32'(lows), 0);

    // 0xA5 8N1: 0,1,0,1,0,0,1,0,1,1
    run_frame(0, 8'hA5, 10, 11'h34A, "8n1 a5");
    // 0x53 7E2: 0,1100101,0,1,1
    run_frame(1, 8'h53, 11, 11'h6A6, "7e2 53");
    // 0x53 8O1: 0,11001010,1,1
    run_frame(2, 8'h53, 11, 11'h6A6, "8o1 53");

    // Burst of 18 offers at full rate: 17 fit (one pops on the way), the 18th is refused
    repeat (2) @(negedge clock_50M);
    rec_sel = 2'd0;
    acc = 0;
    drop_at = -1;
    for (int i = 0; i < 18; i++) begin
      @(negedge clock_50M);
      if (i == 0) rec_on = 1'b1;
      if (wr_ready_a === 1'b1) acc++;
      else if (drop_at < 0) drop_at = i;
      if (i == 17) check("burst count full", 32'(cnt_a), 16);
      set_wr(0, 1'b1, 8'(8'h10 + i));
    end
    @(negedge clock_50M);
    set_wr(0, 1'b0, 8'h00);
    check("burst accepted", 32'(acc), 17);
    check("burst ready drop", 32'(drop_at), 17);
    repeat (670) @(negedge clock_50M);
    rec_on = 1'b0;
    for (int f = 0; f < 17; f++) begin
      check($sformatf("burst byte %0d", f), 32'(line_byte(5 + 40 * f, 8)), 32'(8'h10 + f));
    end
    lows = 0;
    for (int r = 1; r <= 680; r++) if (rec_busy[r] !== 1'b1) lows++;
    check("burst no gap", 32'(lows), 0);
    check("burst frames", 32'(done_count(0, 687)), 17);
    check("burst busy end", 32'(rec_busy[681]), 0);

    // Write coinciding with the pop at the end of the first frame, count held at 3
    repeat (2) @(negedge clock_50M);
    rec_sel = 2'd0;
    for (int t = 0; t <= 41; t++) begin
      @(negedge clock_50M);
      if (t == 0) rec_on = 1'b1;
      if (t < 4) begin
        set_wr(0, 1'b1, 8'(8'h41 + t));
      end else if (t == 41) begin
        check("simul count before", 32'(cnt_a), 3);
        set_wr(0, 1'b1, 8'h45);
      end else begin
        set_wr(0, 1'b0, 8'h00);
      end
    end
    @(negedge clock_50M);
    set_wr(0, 1'b0, 8'h00);
    check("simul count after", 32'(cnt_a), 3);
    check("simul pop cycle done", 32'(rec_done[40]), 1);
    repeat (200) @(negedge clock_50M);
    rec_on = 1'b0;
    for (int f = 0; f < 5; f++) begin
      check($sformatf("simul byte %0d", f), 32'(line_byte(5 + 40 * f, 8)), 32'(8'h41 + f));
    end
    check("simul frames", 32'(done_count(0, 210)), 5);

    // Reset during the data bits of the second of three queued frames
    repeat (2) @(negedge clock_50M);
    rec_sel = 2'd0;
    for (int t = 0; t < 3; t++) begin
      @(negedge clock_50M);
      if (t == 0) rec_on = 1'b1;
      set_wr(0, 1'b1, 8'(8'h31 + t));
    end
    @(negedge clock_50M);
    set_wr(0, 1'b0, 8'h00);
    repeat (48) @(negedge clock_50M);
    check("midrst count before", 32'(cnt_a), 1);
    check("midrst busy before", 32'(busy_a), 1);
    check("midrst frames before", 32'(done_count(0, 50)), 1);
    rst = 1'b1;
    @(negedge clock_50M);
    check("midrst tx", 32'(tx_a), 1);
    check("midrst count", 32'(cnt_a), 0);
    check("midrst busy", 32'(busy_a), 0);
    rst = 1'b0;
    rec_on = 1'b0;
    lows = 0;
    dones = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock_50M);
      if (tx_a !== 1'b1) lows++;
      if (tx_done_a === 1'b1) dones++;
    end
    check("midrst no frames tx", 32'(lows), 0);
    check("midrst no tx_done", 32'(dones), 0);
    check("midrst count stays", 32'(cnt_a), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
